// File: rtl/axi_slave_read_port.sv
// AXI read-address queue and burst expander: one engine request and one R beat per burst beat.
// Optional `AXI_RD_WRAP_EN enables WRAP bursts; without it WRAP is answered as a reserved burst.
module axi_slave_read_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AR_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [2:0]            req_size,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  output logic [1:0]            o_dbg_state
);

  localparam int PW       = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
  localparam int CW       = $clog2(AR_DEPTH + 1);
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [PW-1:0] LAST_IDX = PW'(AR_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload hold steady until that edge.
  logic [ID_WIDTH-1:0]   r_q_id    [AR_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_addr  [AR_DEPTH];
  logic [3:0]            r_q_len   [AR_DEPTH];
  logic [2:0]            r_q_size  [AR_DEPTH];
  logic [1:0]            r_q_burst [AR_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_arready;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_beat_cnt, r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic [2:0]            r_size;
  logic [1:0]            r_burst, r_rresp;
  logic                  r_bad;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_push, w_pop, w_empty, w_last, w_head_bad;
  logic [CW-1:0]         w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_bsz, w_next_addr;
`ifdef AXI_RD_WRAP_EN
  logic [ADDR_WIDTH-1:0] w_wsz, w_h_bmask;
`endif

  assign w_push  = arvalid && r_arready;
  assign w_last  = (r_beat_cnt == r_len);
  assign w_pop   = (r_state == S_RESP) && rready && w_last;
  assign w_empty = (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // arready comes from a register so a full queue never sees push and pop together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_arready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PW'(1);
      r_count   <= w_count_nxt;
      r_arready <= (w_count_nxt != CW'(AR_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_id[r_wr_ptr]    <= arid;
      r_q_addr[r_wr_ptr]  <= araddr;
      r_q_len[r_wr_ptr]   <= arlen;
      r_q_size[r_wr_ptr]  <= arsize;
      r_q_burst[r_wr_ptr] <= arburst;
    end
  end

`ifdef AXI_RD_WRAP_EN
  assign w_h_bmask = (ADDR_WIDTH'(1) << r_q_size[r_rd_ptr]) - ADDR_WIDTH'(1);
`endif

  always_comb begin
    w_head_bad = 1'b0;
    if (r_q_burst[r_rd_ptr] == 2'b11) w_head_bad = 1'b1;
    if (int'(r_q_size[r_rd_ptr]) > MAX_SIZE) w_head_bad = 1'b1;
`ifdef AXI_RD_WRAP_EN
    if (r_q_burst[r_rd_ptr] == 2'b10) begin
      if (!(r_q_len[r_rd_ptr] inside {4'd1, 4'd3, 4'd7, 4'd15})) w_head_bad = 1'b1;
      if ((r_q_addr[r_rd_ptr] & w_h_bmask) != '0) w_head_bad = 1'b1;
    end
`else
    if (r_q_burst[r_rd_ptr] == 2'b10) w_head_bad = 1'b1;
`endif
  end

  always_comb begin
    w_bsz       = ADDR_WIDTH'(1) << r_size;
    w_next_addr = r_addr;
`ifdef AXI_RD_WRAP_EN
    w_wsz       = w_bsz * (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1));
`endif
    case (r_burst)
      2'b01:   w_next_addr = (r_addr & ~(w_bsz - ADDR_WIDTH'(1))) + w_bsz;
`ifdef AXI_RD_WRAP_EN
      2'b10:   w_next_addr = (r_addr & ~(w_wsz - ADDR_WIDTH'(1))) |
                             ((r_addr + w_bsz) & (w_wsz - ADDR_WIDTH'(1)));
`endif
      default: w_next_addr = r_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_nxt = S_REQ;
      S_REQ: begin
        if (r_bad)          w_state_nxt = S_RESP;
        else if (req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: if (rsp_valid) w_state_nxt = S_RESP;
      S_RESP: if (rready) w_state_nxt = w_last ? S_IDLE : S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = (r_state == S_REQ) && !r_bad;
    rvalid    = (r_state == S_RESP);
    rlast     = (r_state == S_RESP) && w_last;
  end

  // Rejected bursts still walk every beat, answering SLVERR without touching the engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_beat_cnt <= '0;
      r_len      <= '0;
      r_id       <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_bad      <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_addr     <= r_q_addr[r_rd_ptr];
          r_beat_cnt <= '0;
          r_len      <= r_q_len[r_rd_ptr];
          r_id       <= r_q_id[r_rd_ptr];
          r_size     <= r_q_size[r_rd_ptr];
          r_burst    <= r_q_burst[r_rd_ptr];
          r_bad      <= w_head_bad;
        end
        S_REQ: if (r_bad) begin
          r_rdata <= '0;
          r_rresp <= 2'b10;
        end
        S_WAIT: if (rsp_valid) begin
          r_rdata <= rsp_data;
          r_rresp <= rsp_err ? 2'b10 : 2'b00;
        end
        S_RESP: if (rready && !w_last) begin
          r_beat_cnt <= r_beat_cnt + 4'd1;
          r_addr     <= w_next_addr;
        end
        default: ;
      endcase
    end
  end

  assign arready     = r_arready;
  assign rid         = r_id;
  assign rdata       = r_rdata;
  assign rresp       = r_rresp;
  assign req_addr    = r_addr;
  assign req_size    = r_size;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_slave_read_port.sv
// Bench for axi_slave_read_port: AR driver, engine responder, R monitor with expected queues,
// and an arithmetic burst model; honours `AXI_RD_WRAP_EN the same way as the design build.
module tb_axi_slave_read_port;

`ifdef AXI_RD_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [1:0]  dbg_state;

  axi_slave_read_port dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [5:0]  exp_q[$];   // {id, last, bad} per R beat
  logic [34:0] req_q[$];   // {size, addr} per engine request
  logic [32:0] eng_q[$];   // {err, data} per engine response
  bit          err_q[$];   // forced error pattern for directed beats

  int n_total = 0;
  int n_bad   = 0;
  int req_hs  = 0;
  int r_beats = 0;
  int epoch   = 0;
  int fixed_dly = -1;
  bit rready_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Reference: beat addresses from plain arithmetic on the burst rules.
  task automatic model_push(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    longint b, w, base, a;
    bit bad;
    b   = longint'(1) << size;
    bad = (burst == 2'd3) || (size > 3'd2);
    if (burst == 2'd2)
      bad = bad || !WRAP_EN || !(len == 1 || len == 3 || len == 7 || len == 15) || (addr % b != 0);
    for (int i = 0; i <= int'(len); i++) begin
      if (!bad) begin
        case (burst)
          2'd0:    a = addr;
          2'd1:    a = (i == 0) ? longint'(addr) : (addr - addr % b) + i * b;
          default: begin
            w    = (len + 1) * b;
            base = addr - addr % w;
            a    = base + ((addr - base) + i * b) % w;
          end
        endcase
        req_q.push_back({size, a[31:0]});
      end
      exp_q.push_back({id, (i == int'(len)), bad});
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!arready) fail_now("ar_timeout");
    else model_push(id, addr, len, size, burst);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
    chk("req_q_empty", 64'(req_q.size()), 0);
    chk("eng_q_empty", 64'(eng_q.size()), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_size", req_size, 0);
  endtask

  initial begin : rready_drv
    rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rready = !rready_hold && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : engine
    logic [34:0] e;
    logic [31:0] d;
    bit er;
    int ep, dl;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && req_ready) begin
        req_hs++;
        if (req_q.size() == 0) fail_now("req_unexpected");
        else begin
          e = req_q.pop_front();
          chk("req_addr", req_addr, e[31:0]);
          chk("req_size", req_size, e[34:32]);
        end
        ep = epoch;
        @(posedge clk); #1;
        req_ready = 1'b0;
        dl = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        for (int k = 0; k < dl; k++) begin
          @(posedge clk); #1;
        end
        if (ep == epoch) begin
          d  = $urandom;
          er = (err_q.size() != 0) ? err_q.pop_front() : ($urandom_range(0, 3) == 0);
          rsp_valid = 1'b1; rsp_data = d; rsp_err = er;
          eng_q.push_back({er, d});
          @(posedge clk); #1;
          rsp_valid = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
        req_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin : monitor
    logic [5:0]  x;
    logic [32:0] r;
    logic [39:0] held;
    bit hv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) hv = 1'b0;
      else begin
        if (hv) chk("r_stable", {rvalid, rid, rlast, rresp, rdata}, held);
        hv = 1'b0;
        if (rvalid && rready) begin
          r_beats++;
          if (exp_q.size() == 0) fail_now("r_unexpected");
          else begin
            x = exp_q.pop_front();
            chk("rid", rid, x[5:2]);
            chk("rlast", rlast, x[1]);
            if (x[0]) begin
              chk("rdata_bad", rdata, 0);
              chk("rresp_bad", rresp, 2'b10);
            end else if (eng_q.size() == 0) fail_now("r_no_engine_data");
            else begin
              r = eng_q.pop_front();
              chk("rdata", rdata, r[31:0]);
              chk("rresp", rresp, {r[32], 1'b0});
            end
          end
        end else if (rvalid) begin
          hv   = 1'b1;
          held = {1'b1, rid, rlast, rresp, rdata};
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, t;
    logic [1:0] bu;
    logic [2:0] sz;
    logic [3:0] ln;
    logic [31:0] ad;
    rst_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("arready_after_reset", arready, 1);

    send_ar(4'd3, 32'h1000, 4'd3, 3'd2, 2'd1); drain();
    send_ar(4'd7, 32'h2008, 4'd3, 3'd2, 2'd2); drain();
    err_q.push_back(1'b0); err_q.push_back(1'b1); err_q.push_back(1'b0);
    send_ar(4'd2, 32'h30, 4'd2, 3'd2, 2'd0); drain();
    send_ar(4'd9, 32'h44, 4'd1, 3'd3, 2'd1); drain();

    // Queue fills with R held off; third AR waits for the first burst to retire.
    rready_hold = 1'b1;
    send_ar(4'd1, 32'h100, 4'd3, 3'd2, 2'd1);
    send_ar(4'd2, 32'h200, 4'd1, 3'd1, 2'd1);
    @(negedge clk);
    chk("arready_full", arready, 0);
    repeat (10) @(negedge clk);
    chk("arready_full_hold", arready, 0);
    base = r_beats;
    @(posedge clk); #1;
    rready_hold = 1'b0;
    send_ar(4'd3, 32'h300, 4'd0, 3'd2, 2'd1);
    chk("ar3_after_pop", 64'(r_beats - base >= 4), 1);
    drain();

    // Reset while the second beat's engine request is outstanding.
    fixed_dly = 8;
    base = req_hs;
    send_ar(4'd5, 32'h500, 4'd3, 3'd2, 2'd1);
    t = 0;
    while (req_hs < base + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (req_hs < base + 2) fail_now("reset_setup_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    epoch++;
    exp_q.delete(); req_q.delete(); eng_q.delete(); err_q.delete();
    @(negedge clk);
    check_reset_outputs();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    fixed_dly = -1;
    repeat (2) begin @(posedge clk); #1; end
    send_ar(4'd6, 32'h4000, 4'd1, 3'd2, 2'd1); drain();

    for (int n = 0; n < 40; n++) begin
      bu = 2'($urandom_range(0, 3));
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      ln = 4'($urandom_range(0, 15));
      if (bu == 2'd2 && $urandom_range(0, 3) != 0) ln = 4'((2 << $urandom_range(0, 3)) - 1);
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      send_ar(4'($urandom_range(0, 15)), ad, ln, sz, bu);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
